// File: rtl/volume_ramp_pkg.sv
// volume_ramp_pkg
//   Shared types and helpers for the volume_ramp block.
//   state_t     : sample-processing FSM states.
//   gain_unity  : unity gain code for an unsigned Q2.(W-2) gain word.
//   ramp_step   : one exponential ramp step toward the target gain.
package volume_ramp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RAMP,
    MULT,
    OUT
  } state_t;

  function automatic int gain_unity(input int gain_width);
    return 1 << (gain_width - 2);
  endfunction

  // The arithmetic shift floors, so negative differences never round to zero;
  // only small positive differences need the +1 nudge to guarantee convergence.
  // |step| <= |diff| always holds, so the gain never overshoots its target.
  function automatic logic signed [31:0] ramp_step(input logic signed [31:0] diff,
                                                   input int              ramp_shift);
    logic signed [31:0] step;
    if (diff == 32'sd0) return 32'sd0;
    step = diff >>> ramp_shift;
    if (step == 32'sd0) step = (diff < 32'sd0) ? -32'sd1 : 32'sd1;
    return step;
  endfunction

endpackage

// File: rtl/volume_ramp_sat.sv
// volume_ramp_sat
//   Combinational round-half-up, arithmetic right shift and saturation of a
//   wide signed product down to OUT_WIDTH bits.
//   din  : signed product, IN_WIDTH bits
//   dout : rounded, saturated result, OUT_WIDTH bits
//   ovf  : high when dout was clamped
module volume_ramp_sat #(
  parameter int IN_WIDTH  = 41,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 14
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        ovf
);

  localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [IN_WIDTH:0] MINV = (IN_WIDTH+1)'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  // One extra bit of headroom so adding the rounding constant cannot wrap.
  function automatic logic signed [IN_WIDTH:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] sum;
    sum = $signed({x[IN_WIDTH-1], x}) + HALF;
    return sum >>> SHIFT;
  endfunction

  // Returns {overflow, data}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [IN_WIDTH:0] x);
    if (x > MAXV)      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (x < MINV) return {1'b1, MINV[OUT_WIDTH-1:0]};
    else               return {1'b0, x[OUT_WIDTH-1:0]};
  endfunction

  logic signed [IN_WIDTH:0] rounded;

  always_comb begin
    rounded     = round_shift(din);
    {ovf, dout} = saturate(rounded);
  end

endmodule

// File: rtl/volume_ramp.sv
// volume_ramp
//   Per-channel volume stage for a TDM sample stream. Each sample fetches the
//   channel's target gain from external RAM, moves that channel's current gain
//   one exponential step toward the target (0 while muted), multiplies, then
//   rounds and saturates back to INPUT_WIDTH. One sample in flight, 5 clk min.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     gain, gain_addr     coefficient RAM read (data 1 clk after address)
//     mute                ramps every channel toward zero gain
//     s_t*                input stream (tdata/tid/tvalid/tready)
//     m_t*                output stream (tdata/tid/tvalid/tready)
//     overflow            current m_tdata was saturated
//   Optional (VOLUME_RAMP_PEAK_EN): peak_sel, peak_clr, peak -- per-channel
//   peak |output| hold, read combinationally.
module volume_ramp
  import volume_ramp_pkg::*;
#(
  parameter int NR_CHANNELS = 3,
  parameter int INPUT_WIDTH = 24,
  parameter int GAIN_WIDTH  = 16,
  parameter int RAMP_SHIFT  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [GAIN_WIDTH-1:0]          gain,
  output logic [$clog2(NR_CHANNELS)-1:0] gain_addr,
  input  logic                           mute,
  input  logic signed [INPUT_WIDTH-1:0]  s_tdata,
  input  logic [$clog2(NR_CHANNELS)-1:0] s_tid,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic signed [INPUT_WIDTH-1:0]  m_tdata,
  output logic [$clog2(NR_CHANNELS)-1:0] m_tid,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           overflow
`ifdef VOLUME_RAMP_PEAK_EN
  ,
  input  logic [$clog2(NR_CHANNELS)-1:0] peak_sel,
  input  logic                           peak_clr,
  output logic [INPUT_WIDTH-2:0]         peak
`endif
);

  localparam int CW      = $clog2(NR_CHANNELS);
  localparam int PROD_W  = INPUT_WIDTH + GAIN_WIDTH + 1;
  localparam int FRAC    = $clog2(gain_unity(GAIN_WIDTH));
  localparam logic [CW-1:0] LAST_CH = CW'(NR_CHANNELS - 1);

  state_t                        state;
  logic signed [INPUT_WIDTH-1:0] sample_p0;
  logic [CW-1:0]                 tid_p0;
  logic [GAIN_WIDTH-1:0]         gain_p1;
  logic [GAIN_WIDTH-1:0]         cur_gain [NR_CHANNELS];

  logic [GAIN_WIDTH-1:0]         tgt;
  logic [GAIN_WIDTH-1:0]         cur_sel;
  logic signed [GAIN_WIDTH:0]    diff;
  logic signed [31:0]            step;
  logic [GAIN_WIDTH-1:0]         gain_new;
  logic signed [PROD_W-1:0]      prod;
  logic signed [INPUT_WIDTH-1:0] sat_data;
  logic                          sat_ovf;

  // Ramp arithmetic; the unsigned add wraps correctly because the step never
  // carries the gain outside [0, target].
  always_comb begin
    tgt      = mute ? '0 : gain;
    cur_sel  = cur_gain[tid_p0];
    diff     = $signed({1'b0, tgt}) - $signed({1'b0, cur_sel});
    step     = ramp_step(32'(diff), RAMP_SHIFT);
    gain_new = cur_sel + GAIN_WIDTH'(step);
  end

  always_comb begin
    prod = PROD_W'(sample_p0) * PROD_W'($signed({1'b0, gain_p1}));
  end

  volume_ramp_sat #(
    .IN_WIDTH (PROD_W),
    .OUT_WIDTH(INPUT_WIDTH),
    .SHIFT    (FRAC)
  ) u_sat (
    .din (prod),
    .dout(sat_data),
    .ovf (sat_ovf)
  );

  // Stage p0: sample capture at handshake. Stage p1: ramped gain for MULT.
  always_ff @(posedge clk) begin
    if (state == IDLE && s_tready && s_tvalid) begin
      sample_p0 <= s_tdata;
      tid_p0    <= s_tid;
    end
    if (state == RAMP) gain_p1 <= gain_new;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tid     <= '0;
      overflow  <= 1'b0;
      gain_addr <= '0;
      for (int i = 0; i < NR_CHANNELS; i++) cur_gain[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range channels are accepted here and silently dropped.
          s_tready <= 1'b1;
          if (s_tready && s_tvalid && s_tid <= LAST_CH) begin
            s_tready  <= 1'b0;
            gain_addr <= s_tid;
            state     <= FETCH;
          end
        end
        FETCH: state <= RAMP;
        RAMP: begin
          cur_gain[tid_p0] <= gain_new;
          state            <= MULT;
        end
        MULT: begin
          m_tdata  <= sat_data;
          m_tid    <= tid_p0;
          overflow <= sat_ovf;
          m_tvalid <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            s_tready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VOLUME_RAMP_PEAK_EN
  logic [INPUT_WIDTH-2:0] peak_hold [NR_CHANNELS];
  logic [INPUT_WIDTH-2:0] out_mag;

  // The most negative sample has no positive twin; clamp it to full scale.
  always_comb begin
    if (!m_tdata[INPUT_WIDTH-1])
      out_mag = m_tdata[INPUT_WIDTH-2:0];
    else if (m_tdata[INPUT_WIDTH-2:0] == '0)
      out_mag = '1;
    else
      out_mag = (INPUT_WIDTH-1)'(-m_tdata);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || peak_clr) begin
      for (int i = 0; i < NR_CHANNELS; i++) peak_hold[i] <= '0;
    end else if (state == OUT && m_tvalid && m_tready && out_mag > peak_hold[m_tid]) begin
      peak_hold[m_tid] <= out_mag;
    end
  end

  always_comb begin
    peak = (peak_sel <= LAST_CH) ? peak_hold[peak_sel] : '0;
  end
`endif

endmodule

// File: tb/tb_volume_ramp.sv
// tb_volume_ramp
//   Directed bench for volume_ramp with a gain-RAM model, a reference model of
//   the per-channel ramp / round / saturate, and a scoreboard queue.
//   Peak-hold checks are compiled in when VOLUME_RAMP_PEAK_EN is defined.
module tb_volume_ramp;

  localparam int NCH   = 3;
  localparam int IW    = 24;
  localparam int GW    = 16;
  localparam int CW    = 2;
  localparam int UNITY = 16384;

  typedef struct {
    logic signed [IW-1:0] data;
    logic [CW-1:0]        tid;
    logic                 ovf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [GW-1:0]        gain = '0;
  logic [CW-1:0]        gain_addr;
  logic                 mute = 1'b0;
  logic signed [IW-1:0] s_tdata = '0;
  logic [CW-1:0]        s_tid = '0;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic signed [IW-1:0] m_tdata;
  logic [CW-1:0]        m_tid;
  logic                 m_tvalid;
  logic                 m_tready = 1'b1;
  logic                 overflow;
`ifdef VOLUME_RAMP_PEAK_EN
  logic [CW-1:0]        peak_sel = '0;
  logic                 peak_clr = 1'b0;
  logic [IW-2:0]        peak;
`endif

  logic [GW-1:0] gain_mem [4];
  int            mgain [NCH];
  exp_t          sb [$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) gain <= gain_mem[gain_addr];

  volume_ramp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gain     (gain),
    .gain_addr(gain_addr),
    .mute     (mute),
    .s_tdata  (s_tdata),
    .s_tid    (s_tid),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tid    (m_tid),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .overflow (overflow)
`ifdef VOLUME_RAMP_PEAK_EN
    ,
    .peak_sel (peak_sel),
    .peak_clr (peak_clr),
    .peak     (peak)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_step(input int cur, input int tgt);
    int diff, step;
    diff = tgt - cur;
    if (diff == 0) return cur;
    step = diff >>> 6;
    if (step == 0) step = (diff > 0) ? 1 : -1;
    return cur + step;
  endfunction

  function automatic exp_t model_out(input int s, input int g, input int tid);
    exp_t   e;
    longint r;
    r = ((longint'(s) * longint'(g)) + 64'sd8192) >>> 14;
    e.tid = CW'(tid);
    if (r > 64'sd8388607)       begin e.data = 24'sh7FFFFF; e.ovf = 1'b1; end
    else if (r < -64'sd8388608) begin e.data = 24'sh800000; e.ovf = 1'b1; end
    else                        begin e.data = IW'(r);      e.ovf = 1'b0; end
    return e;
  endfunction

  task automatic send(input int s, input int tid);
    bit ok = 1'b0;
    s_tdata  = IW'(s);
    s_tid    = CW'(tid);
    s_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    s_tvalid = 1'b0;
    check("s_tready_handshake", 64'(ok), 64'd1);
    if (ok && tid < NCH) begin
      mgain[tid] = model_step(mgain[tid], mute ? 0 : int'(gain_mem[tid]));
      sb.push_back(model_out(s, mgain[tid], tid));
    end
  endtask

  // Waits for m_tvalid, compares against the scoreboard head; completes the
  // transfer only when m_tready is high.
  task automatic recv(input bit chk_lat, output logic signed [IW-1:0] got);
    exp_t e;
    int   n = 0;
    got = '0;
    while (!m_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("m_tvalid_rise", 64'(m_tvalid), 64'd1);
    if (chk_lat) check("latency", 64'(n), 64'd4);
    if (m_tvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("m_tdata", m_tdata, e.data);
        check("m_tid", 64'(m_tid), 64'(e.tid));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
      got = m_tdata;
      if (m_tready) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic sample(input int s, input int tid, output logic signed [IW-1:0] got);
    send(s, tid);
    recv(1'b1, got);
  endtask

  task automatic converge(input int s, input int tid, input int tgt, input int max_n,
                          output logic signed [IW-1:0] got);
    got = '0;
    for (int i = 0; i < max_n && mgain[tid] != tgt; i++) sample(s, tid, got);
  endtask

  initial begin
    logic signed [IW-1:0] got, prev, held_d;
    logic [CW-1:0]        held_t;

    gain_mem[0] = 16'h4000;
    gain_mem[1] = 16'hC000;
    gain_mem[2] = 16'h4000;
    gain_mem[3] = 16'h0000;
    for (int i = 0; i < NCH; i++) mgain[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'sd0);
    check("rst_m_tid", 64'(m_tid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_gain_addr", 64'(gain_addr), 64'd0);
    rst_n = 1'b1;

    // 1: fade-in from zero gain to unity, monotonic, no overshoot
    prev = '0;
    got  = '0;
    for (int i = 0; i < 800 && mgain[0] != UNITY; i++) begin
      sample(1000, 0, got);
      check("t1_monotonic", 64'(got >= prev && got <= 24'sd1000), 64'd1);
      prev = got;
    end
    check("t1_final", got, 64'sd1000);

    // 2: full-scale samples at unity pass unchanged
    sample(-8388608, 0, got);
    check("t2_neg_fs", got, -64'sd8388608);
    check("t2_neg_ovf", 64'(overflow), 64'd0);
    sample(8388607, 0, got);
    check("t2_pos_fs", got, 64'sd8388607);
    sample(1000, 2, got);

    // 3: gain 3.0 saturates both rails
    converge(4000000, 1, 49152, 800, got);
    sample(4000000, 1, got);
    check("t3_pos_sat", got, 64'sd8388607);
    check("t3_pos_ovf", 64'(overflow), 64'd1);
    sample(-4000000, 1, got);
    check("t3_neg_sat", got, -64'sd8388608);
    check("t3_neg_ovf", 64'(overflow), 64'd1);

    // 4: mute decays to zero, unmute returns to unity
    mute = 1'b1;
    converge(1000, 0, 0, 700, got);
    check("t4_muted", got, 64'sd0);
    mute = 1'b0;
    converge(1000, 0, UNITY, 700, got);
    check("t4_unmuted", got, 64'sd1000);

    // 5: output stall holds data; invalid channel is dropped
    m_tready = 1'b0;
    send(1234, 2);
    recv(1'b1, held_d);
    held_t = m_tid;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_hold_data", m_tdata, held_d);
      check("t5_hold_tid", 64'(m_tid), 64'(held_t));
      check("t5_hold_valid", 64'(m_tvalid), 64'd1);
      check("t5_s_tready_low", 64'(s_tready), 64'd0);
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_released", 64'(m_tvalid), 64'd0);
    send(77, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_drop_no_valid", 64'(m_tvalid), 64'd0);
    end
    @(posedge clk);
    #1;
    sample(-1000, 0, got);
    check("t5_after_drop", got, -64'sd1000);

`ifdef VOLUME_RAMP_PEAK_EN
    // 6: peak hold
    gain_mem[1] = 16'h4000;
    converge(100, 1, UNITY, 800, got);
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    peak_sel = 2'd1;
    #1;
    check("t6_peak_cleared", 64'(peak), 64'd0);
    sample(500, 1, got);
    sample(-700, 1, got);
    check("t6_peak_700", 64'(peak), 64'd700);
    peak_sel = 2'd0;
    #1;
    check("t6_peak_ch0", 64'(peak), 64'd0);
    peak_sel = 2'd1;
    sample(-8388608, 1, got);
    check("t6_peak_clamp", 64'(peak), 64'd8388607);
    peak_clr = 1'b1;
    @(posedge clk);
    #1;
    peak_clr = 1'b0;
    check("t6_peak_clr", 64'(peak), 64'd0);
`endif

    // 7: reset while a sample sits in OUT
    m_tready = 1'b0;
    send(1000, 0);
    recv(1'b0, got);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t7_rst_m_tdata", m_tdata, 64'sd0);
    check("t7_rst_s_tready", 64'(s_tready), 64'd0);
    rst_n    = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < NCH; i++) mgain[i] = 0;
    sb.delete();
    sample(1000, 0, got);
    check("t7_fade_in", got, 64'sd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
